// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: receiver FIFO handshake plus decoded key-event bus.
// master = decoder side, slave = receiver/console side.
interface ps2_key_decoder_if;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_press;
    logic       key_repeat;
    logic [7:0] key_ascii;
    logic [7:0] key_count;
    logic       shift_on;
    logic       caps_on;

    modport master (
        input  kbd_data, kbd_ready,
        output kbd_nextdata_n, key_valid, key_code, key_ext, key_press,
               key_repeat, key_ascii, key_count, shift_on, caps_on
    );
    modport slave (
        output kbd_data, kbd_ready,
        input  kbd_nextdata_n, key_valid, key_code, key_ext, key_press,
               key_repeat, key_ascii, key_count, shift_on, caps_on
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 byte stream to key events with E0/F0 prefixes, typematic, shift/caps.
// Define KBD_ASCII_EN to drive key_ascii from the set-2 lookup; otherwise it is constant 0.
module ps2_key_decoder (
    input logic clk,
    input logic rst,
    ps2_key_decoder_if.master k
);
    typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;
    state_t     state;
    logic [7:0] byte_q, held_code, ascii_n;
    logic       ext_pend, brk_pend, held_ext, held_v, lshift, rshift, press, match;

    assign press      = ~brk_pend;
    assign match      = held_v && held_code == byte_q && held_ext == ext_pend;
    assign k.shift_on = lshift | rshift;

`ifdef KBD_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic up);
        logic [7:0] a;
        case (c)
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
            8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
            8'h3E: a = "8";  8'h46: a = "9";
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return (up && a >= "a" && a <= "z") ? a - 8'h20 : a;
    endfunction
    // Case uses the shift/caps state from before this byte is applied.
    assign ascii_n = ext_pend ? 8'h00 : to_ascii(byte_q, k.shift_on ^ k.caps_on);
`else
    assign ascii_n = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            byte_q           <= 8'h00;
            ext_pend         <= 1'b0;
            brk_pend         <= 1'b0;
            held_code        <= 8'h00;
            held_ext         <= 1'b0;
            held_v           <= 1'b0;
            lshift           <= 1'b0;
            rshift           <= 1'b0;
            k.kbd_nextdata_n <= 1'b1;
            k.key_valid      <= 1'b0;
            k.key_code       <= 8'h00;
            k.key_ext        <= 1'b0;
            k.key_press      <= 1'b0;
            k.key_repeat     <= 1'b0;
            k.key_ascii      <= 8'h00;
            k.key_count      <= 8'h00;
            k.caps_on        <= 1'b0;
        end else begin
            k.key_valid <= 1'b0;
            case (state)
                IDLE: if (k.kbd_ready) begin
                    byte_q           <= k.kbd_data;
                    k.kbd_nextdata_n <= 1'b0;
                    state            <= ACK;
                end
                ACK: begin
                    k.kbd_nextdata_n <= 1'b1;
                    state            <= GAP;
                    if (byte_q == 8'hE0) ext_pend <= 1'b1;
                    else if (byte_q == 8'hF0) brk_pend <= 1'b1;
                    else if (byte_q != 8'hE1) begin
                        ext_pend     <= 1'b0;
                        brk_pend     <= 1'b0;
                        k.key_valid  <= 1'b1;
                        k.key_code   <= byte_q;
                        k.key_ext    <= ext_pend;
                        k.key_press  <= press;
                        k.key_repeat <= press && match;
                        k.key_ascii  <= ascii_n;
                        if (press && !match) begin
                            k.key_count <= k.key_count + 8'd1;
                            held_code   <= byte_q;
                            held_ext    <= ext_pend;
                            held_v      <= 1'b1;
                        end
                        if (!press && match) held_v <= 1'b0;
                        if (!ext_pend && byte_q == 8'h12) lshift <= press;
                        if (!ext_pend && byte_q == 8'h59) rshift <= press;
                        if (!ext_pend && byte_q == 8'h58 && press && !match) k.caps_on <= ~k.caps_on;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: FIFO-fed byte vectors, scoreboard of expected events, reset-in-ACK and count wrap.
module tb_ps2_key_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_key_decoder_if kif();
    ps2_key_decoder dut (.clk(clk), .rst(rst), .k(kif));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [7:0] code;
        logic       ext, press, rep;
        logic [7:0] cnt;
        logic       shf, caps;
        logic [7:0] asc;
    } vec_t;

    vec_t       vt[33];
    vec_t       sb[$];
    vec_t       e, w;
    logic [7:0] fifo[$];
    int         pass_n = 0, total_n = 0, cyc = 0, last_pop = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_nextdata_n"}, 32'(kif.kbd_nextdata_n), 32'd1);
        chk({tag, "_valid"}, 32'(kif.key_valid), 32'd0);
        chk({tag, "_code"}, 32'(kif.key_code), 32'd0);
        chk({tag, "_flags"}, 32'({kif.key_ext, kif.key_press, kif.key_repeat}), 32'd0);
        chk({tag, "_ascii"}, 32'(kif.key_ascii), 32'd0);
        chk({tag, "_count"}, 32'(kif.key_count), 32'd0);
        chk({tag, "_shift_caps"}, 32'({kif.shift_on, kif.caps_on}), 32'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((fifo.size() != 0 || sb.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        chk({name, "_drained"}, 32'(sb.size() + fifo.size()), 32'd0);
    endtask

    always @(posedge clk) cyc++;

    // Receiver FIFO model: pop on the strobe, ready/data refreshed away from the clock edge.
    always @(negedge clk) begin
        if (rst) fifo.delete();
        else if (kif.kbd_nextdata_n == 1'b0 && fifo.size() != 0) void'(fifo.pop_front());
        kif.kbd_ready = fifo.size() != 0;
        kif.kbd_data  = fifo.size() != 0 ? fifo[0] : 8'h00;
    end

    always @(negedge clk) if (!rst) begin
        if (kif.kbd_nextdata_n == 1'b0) begin
            chk("pop_gap", 32'((cyc - last_pop) >= 3), 32'd1);
            last_pop = cyc;
        end
        if (kif.key_valid) begin
            if (sb.size() == 0) chk("unexpected_event", 32'(kif.key_code), 32'hFFFF);
            else begin
                e = sb.pop_front();
                chk("code", 32'(kif.key_code), 32'(e.code));
                chk("ext", 32'(kif.key_ext), 32'(e.ext));
                chk("press", 32'(kif.key_press), 32'(e.press));
                chk("repeat", 32'(kif.key_repeat), 32'(e.rep));
                chk("count", 32'(kif.key_count), 32'(e.cnt));
                chk("shift_on", 32'(kif.shift_on), 32'(e.shf));
                chk("caps_on", 32'(kif.caps_on), 32'(e.caps));
`ifdef KBD_ASCII_EN
                chk("ascii", 32'(kif.key_ascii), 32'(e.asc));
`else
                chk("ascii", 32'(kif.key_ascii), 32'd0);
`endif
            end
        end
    end

    initial begin
        vt = '{
            '{8'h1C, 1, 8'h1C, 0, 1, 0, 8'd1,  0, 0, 8'h61},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h1C, 1, 8'h1C, 0, 0, 0, 8'd1,  0, 0, 8'h61},
            '{8'h1C, 1, 8'h1C, 0, 1, 0, 8'd2,  0, 0, 8'h61},
            '{8'h1C, 1, 8'h1C, 0, 1, 1, 8'd2,  0, 0, 8'h61},
            '{8'h1C, 1, 8'h1C, 0, 1, 1, 8'd2,  0, 0, 8'h61},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h1C, 1, 8'h1C, 0, 0, 0, 8'd2,  0, 0, 8'h61},
            '{8'hE0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h75, 1, 8'h75, 1, 1, 0, 8'd3,  0, 0, 8'h00},
            '{8'hE0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h75, 1, 8'h75, 1, 0, 0, 8'd3,  0, 0, 8'h00},
            '{8'h12, 1, 8'h12, 0, 1, 0, 8'd4,  1, 0, 8'h00},
            '{8'h1C, 1, 8'h1C, 0, 1, 0, 8'd5,  1, 0, 8'h41},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h12, 1, 8'h12, 0, 0, 0, 8'd5,  0, 0, 8'h00},
            '{8'h58, 1, 8'h58, 0, 1, 0, 8'd6,  0, 1, 8'h00},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h58, 1, 8'h58, 0, 0, 0, 8'd6,  0, 1, 8'h00},
            '{8'h1C, 1, 8'h1C, 0, 1, 0, 8'd7,  0, 1, 8'h41},
            '{8'hE1, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'hE1, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h1C, 1, 8'h1C, 0, 0, 0, 8'd7,  0, 1, 8'h41},
            '{8'h58, 1, 8'h58, 0, 1, 0, 8'd8,  0, 0, 8'h00},
            '{8'h58, 1, 8'h58, 0, 1, 1, 8'd8,  0, 0, 8'h00},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h58, 1, 8'h58, 0, 0, 0, 8'd8,  0, 0, 8'h00},
            '{8'h59, 1, 8'h59, 0, 1, 0, 8'd9,  1, 0, 8'h00},
            '{8'h2A, 1, 8'h2A, 0, 1, 0, 8'd10, 1, 0, 8'h56},
            '{8'hF0, 0, 8'h00, 0, 0, 0, 8'd0,  0, 0, 8'h00},
            '{8'h59, 1, 8'h59, 0, 0, 0, 8'd10, 0, 0, 8'h00}
        };
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        @(posedge clk);
        for (int i = 0; i < 33; i++) begin
            fifo.push_back(vt[i].b);
            if (vt[i].ev) sb.push_back(vt[i]);
        end
        drain("table");

        // Alternating makes never match the held key, so each one counts: 10 + 250 wraps to 4.
        @(posedge clk);
        for (int i = 0; i < 250; i++) begin
            w = '{(i % 2) ? 8'h32 : 8'h1C, 1, (i % 2) ? 8'h32 : 8'h1C, 0, 1, 0,
                  8'(11 + i), 0, 0, (i % 2) ? 8'h62 : 8'h61};
            fifo.push_back(w.b);
            sb.push_back(w);
        end
        drain("wrap");
        chk("wrap_final_count", 32'(kif.key_count), 32'd4);

        @(posedge clk);
        fifo.push_back(8'hF0);
        begin
            int n = 0;
            @(negedge clk);
            while (kif.kbd_nextdata_n !== 1'b0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rst_ack_reached", 32'(n < 50), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("ack_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        fifo.push_back(8'h1C);
        sb.push_back('{8'h1C, 1, 8'h1C, 0, 1, 0, 8'd1, 0, 0, 8'h61});
        drain("after_reset");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
